// File: rtl/serial_pkg.sv
// Shared definitions for the serial line transmitter/receiver pair.
package serial_pkg;

    // Receiver framing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } t_rx_state;

    // Line levels of the framing bits; the line idles at STOP_LVL.
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Cycle count from the detected start edge to the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_d;
    logic [1:0] ff_q;

    // Shift the raw input through two stages.
    always_comb begin
        ff_d = {ff_q[0], d};
    end

    // Synchronizer flops; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q <= {2{RESET_VAL}};
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/serial_rx.sv
// Serial line receiver: idle-high, one start bit, DATA_BITS data bits LSB
// first, one stop bit. Each bit is sampled once at mid-bit.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    t_rx_state            state_d, state_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic [IDX_W-1:0]     idx_d, idx_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic                 valid_d, valid_q;
    logic                 frame_err_d, frame_err_q;
    logic                 half_tc;
    logic                 bit_tc;

    sync_2ff #(
        .RESET_VAL(STOP_LVL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    assign half_tc = (cnt_q == HALF);
    assign bit_tc  = (cnt_q == LAST_CNT);

    // Next-state decision; every branch looks only at the synchronized line.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_s == START_LVL) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is no longer low at mid-bit was a glitch.
                if (half_tc) begin
                    state_d = (rx_s == START_LVL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (bit_tc && (idx_q == LAST_IDX)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tc) begin
                    state_d = (rx_s == STOP_LVL) ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Wait out a held-low line so it cannot start false frames.
                if (rx_s == STOP_LVL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter, shift register and output pulse next values.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: begin
                if (half_tc) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_tc) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    // Clear rather than wrap after the final data bit.
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_tc) begin
                    cnt_d = '0;
                    if (rx_s == STOP_LVL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
                idx_d = '0;
            end
            default: begin
                cnt_d = '0;
                idx_d = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit timing counters and the incoming shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Registered outputs: held word and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a 16x/8-bit instance and a 4x/7-bit instance.
module tb_serial_rx;

    localparam int CPB0  = 16;
    localparam int DB0   = 8;
    localparam int HALF0 = CPB0 / 2 - 1;
    localparam int LAT0  = 2 + HALF0 + 1 + (DB0 + 1) * CPB0 + 1;
    localparam int CPB1  = 4;
    localparam int DB1   = 7;
    localparam int HALF1 = CPB1 / 2 - 1;
    localparam int LAT1  = 2 + HALF1 + 1 + (DB1 + 1) * CPB1 + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx0, rx1;
    logic [DB0-1:0] data0;
    logic [DB1-1:0] data1;
    logic           valid0, ferr0, busy0;
    logic           valid1, ferr1, busy1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DB0-1:0] exp0_data[$];
    int             exp0_cyc[$];
    logic [DB0-1:0] obs0_data[$];
    int             obs0_cyc[$];
    logic           obs0_busy[$];
    logic [DB1-1:0] exp1_data[$];
    int             exp1_cyc[$];
    logic [DB1-1:0] obs1_data[$];
    int             obs1_cyc[$];
    int ferr0_cnt = 0;
    int ferr1_cnt = 0;
    int both0 = 0;
    int run0 = 0;
    int gap0 = 0;

    serial_rx #(.CLKS_PER_BIT(CPB0), .DATA_BITS(DB0)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data(data0),
        .valid(valid0), .frame_err(ferr0), .busy(busy0)
    );

    serial_rx #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data(data1),
        .valid(valid1), .frame_err(ferr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid0) begin
            obs0_data.push_back(data0);
            obs0_cyc.push_back(cyc);
            obs0_busy.push_back(busy0);
        end
        if (ferr0) ferr0_cnt++;
        if (valid0 && ferr0) both0++;
        if (busy0) begin
            if (run0 > gap0) gap0 = run0;
            run0 = 0;
        end else begin
            run0++;
        end
        if (valid1) begin
            obs1_data.push_back(data1);
            obs1_cyc.push_back(cyc);
        end
        if (ferr1) ferr1_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit0(input logic v, input int n);
        rx0 = v;
        step(n);
    endtask

    task automatic send0(input logic [DB0-1:0] b, input logic stop);
        if (stop) begin
            exp0_data.push_back(b);
            exp0_cyc.push_back(cyc + LAT0);
        end
        bit0(1'b0, CPB0);
        for (int i = 0; i < DB0; i++) bit0(b[i], CPB0);
        bit0(stop, CPB0);
    endtask

    // Noisy mode holds each bit's true level only around its sample cycle.
    task automatic send1(input logic [DB1-1:0] b, input bit noisy);
        logic v;
        exp1_data.push_back(b);
        exp1_cyc.push_back(cyc + LAT1);
        rx1 = 1'b0;
        step(CPB1);
        for (int i = 0; i <= DB1; i++) begin
            v = (i < DB1) ? b[i] : 1'b1;
            for (int c = 0; c < CPB1; c++) begin
                if (noisy && (c != 2) && !((i == DB1) && (c == 3))) rx1 = ~v;
                else rx1 = v;
                step(1);
            end
        end
        rx1 = 1'b1;
    endtask

    task automatic wait_obs0(input int n);
        for (int i = 0; i < 60 && obs0_data.size() < n; i++) step(1);
    endtask

    task automatic clear0();
        exp0_data.delete(); exp0_cyc.delete();
        obs0_data.delete(); obs0_cyc.delete(); obs0_busy.delete();
        ferr0_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        step(3);
        checks++;
        if ({data0, valid0, ferr0, busy0} !== '0) begin
            failures++;
            $display("FAIL reset_outs0 got=%h/%b/%b/%b want=0", data0, valid0, ferr0, busy0);
        end
        checks++;
        if ({data1, valid1, ferr1, busy1} !== '0) begin
            failures++;
            $display("FAIL reset_outs1 got=%h/%b/%b/%b want=0", data1, valid1, ferr1, busy1);
        end
        rst = 1'b1;
        step(20);
        checks++;
        if (busy0 !== 1'b0 || obs0_data.size() != 0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b frames=%0d want 0/0", busy0, obs0_data.size());
        end
    endtask

    task automatic test_single();
        logic [DB0-1:0] want;
        int wcyc;
        clear0();
        send0(8'hA5, 1'b1);
        wait_obs0(1);
        checks++;
        if (obs0_data.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d want=1", obs0_data.size());
        end else begin
            want = exp0_data.pop_front();
            wcyc = exp0_cyc.pop_front();
            checks++;
            if (obs0_data[0] !== want) begin
                failures++;
                $display("FAIL single_data got=%h want=%h", obs0_data[0], want);
            end
            checks++;
            if (obs0_cyc[0] != wcyc) begin
                failures++;
                $display("FAIL single_latency got=%0d want=%0d", obs0_cyc[0], wcyc);
            end
            checks++;
            if (obs0_busy[0] !== 1'b0) begin
                failures++;
                $display("FAIL busy_at_valid got=%b want=0", obs0_busy[0]);
            end
        end
        step(10);
        checks++;
        if (data0 !== 8'hA5 || valid0 !== 1'b0 || ferr0_cnt != 0) begin
            failures++;
            $display("FAIL single_hold data=%h valid=%b ferrs=%0d want a5/0/0", data0, valid0, ferr0_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [DB0-1:0] want;
        int wcyc;
        clear0();
        send0(8'h00, 1'b1);
        gap0 = 0;
        send0(8'hFF, 1'b1);
        wait_obs0(2);
        checks++;
        if (obs0_data.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=2", obs0_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                want = exp0_data.pop_front();
                wcyc = exp0_cyc.pop_front();
                checks++;
                if (obs0_data[i] !== want || obs0_cyc[i] != wcyc) begin
                    failures++;
                    $display("FAIL b2b_frame%0d got=%h@%0d want=%h@%0d", i, obs0_data[i], obs0_cyc[i], want, wcyc);
                end
            end
        end
        checks++;
        if (gap0 != CPB0 - 1 - HALF0) begin
            failures++;
            $display("FAIL b2b_busy_gap got=%0d want=%0d", gap0, CPB0 - 1 - HALF0);
        end
    endtask

    task automatic test_glitch();
        int k;
        clear0();
        bit0(1'b0, 4);
        rx0 = 1'b1;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_rise got=%b want=1", busy0);
        end
        k = 0;
        while (busy0 && k < 10) begin
            step(1);
            k++;
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_fall got=%b want=0 after 10 cycles", busy0);
        end
        step(30);
        checks++;
        if (obs0_data.size() != 0 || ferr0_cnt != 0) begin
            failures++;
            $display("FAIL glitch_outputs valids=%0d ferrs=%0d want 0/0", obs0_data.size(), ferr0_cnt);
        end
    endtask

    task automatic test_frame_err();
        logic [DB0-1:0] want;
        clear0();
        send0(8'h11, 1'b1);
        send0(8'h3C, 1'b0);
        bit0(1'b0, 40);
        checks++;
        if (obs0_data.size() != 1) begin
            failures++;
            $display("FAIL ferr_valid_count got=%0d want=1", obs0_data.size());
        end else begin
            want = exp0_data.pop_front();
            checks++;
            if (obs0_data[0] !== want) begin
                failures++;
                $display("FAIL ferr_good_data got=%h want=%h", obs0_data[0], want);
            end
        end
        checks++;
        if (ferr0_cnt != 1) begin
            failures++;
            $display("FAIL ferr_pulse got=%0d want=1", ferr0_cnt);
        end
        checks++;
        if (data0 !== 8'h11 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL ferr_hold data=%h busy=%b want 11/1", data0, busy0);
        end
        rx0 = 1'b1;
        step(5);
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL ferr_release busy got=%b want=0", busy0);
        end
        step(200);
        checks++;
        if (obs0_data.size() != 1 || ferr0_cnt != 1) begin
            failures++;
            $display("FAIL ferr_no_more valids=%0d ferrs=%0d want 1/1", obs0_data.size(), ferr0_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [DB0-1:0] b;
        logic [DB0-1:0] want;
        b = 8'h77;
        clear0();
        bit0(1'b0, CPB0);
        for (int i = 0; i < 4; i++) bit0(b[i], CPB0);
        rx0 = b[4];
        step(5);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({data0, valid0, ferr0, busy0} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h/%b/%b/%b want=0", data0, valid0, ferr0, busy0);
        end
        rx0 = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        checks++;
        if ({data0, valid0, ferr0, busy0} !== '0) begin
            failures++;
            $display("FAIL after_reset got=%h/%b/%b/%b want=0", data0, valid0, ferr0, busy0);
        end
        step(200);
        checks++;
        if (obs0_data.size() != 0 || ferr0_cnt != 0) begin
            failures++;
            $display("FAIL aborted_frame valids=%0d ferrs=%0d want 0/0", obs0_data.size(), ferr0_cnt);
        end
        send0(8'h5A, 1'b1);
        wait_obs0(1);
        checks++;
        if (obs0_data.size() != 1) begin
            failures++;
            $display("FAIL post_reset_count got=%0d want=1", obs0_data.size());
        end else begin
            want = exp0_data.pop_front();
            checks++;
            if (obs0_data[0] !== want) begin
                failures++;
                $display("FAIL post_reset_data got=%h want=%h", obs0_data[0], want);
            end
        end
    endtask

    task automatic test_small_cfg();
        logic [DB1-1:0] want;
        int wcyc;
        ferr1_cnt = 0;
        send1(7'h55, 1'b0);
        step(10);
        send1(7'h33, 1'b1);
        step(10);
        checks++;
        if (obs1_data.size() != 2) begin
            failures++;
            $display("FAIL small_count got=%0d want=2", obs1_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                want = exp1_data.pop_front();
                wcyc = exp1_cyc.pop_front();
                checks++;
                if (obs1_data[i] !== want || obs1_cyc[i] != wcyc) begin
                    failures++;
                    $display("FAIL small_frame%0d got=%h@%0d want=%h@%0d", i, obs1_data[i], obs1_cyc[i], want, wcyc);
                end
            end
        end
        checks++;
        if (ferr1_cnt != 0) begin
            failures++;
            $display("FAIL small_ferr got=%0d want=0", ferr1_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_small_cfg();
        checks++;
        if (both0 != 0) begin
            failures++;
            $display("FAIL valid_ferr_overlap got=%0d want=0", both0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
